conv_puncturer: RTL and testbench
=================================

Name: conv_puncturer

Overview:
- Puncturer stage directly downstream of the 802.11a PLCP DATA convolutional encoder.
- Consumes the serial rate-1/2 coded stream (A0 B0 A1 B1 ...) on the encoder's 2x Clock.
- Deletes bits per the 802.11a puncturing pattern for the selected coding rate (1/2, 2/3, 3/4).
- Emits the surviving bits through a small FIFO with valid/ready handshake toward the interleaver.

Parameters:
- FIFO_AW, 3, FIFO address width; depth = 2^FIFO_AW entries (legal range 1..6).

Ports:
- Clock     input   1           2x main clock; all state changes on posedge.
- Reset     input   1           asynchronous, active-high reset.
- Start     input   1           one-cycle pulse at frame start: clears phase, latches Rate.
- Rate      input   2           00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = reserved (treated as 1/2). Sampled only on Start.
- InBit     input   1           coded bit from encoder.
- InValid   input   1           InBit valid this cycle.
- InReady   output  1           puncturer can accept a bit.
- OutBit    output  1           punctured bit at FIFO head.
- OutValid  output  1           OutBit valid.
- OutReady  input   1           downstream accepts OutBit.
- Level     output  FIFO_AW+1   current FIFO occupancy, 0..2^FIFO_AW.

Behaviour:
- Reset is asynchronous and active-high, on Clock. Reset values:
  - latched rate = 1/2; phase = 0; FIFO empty.
  - Level = 0, OutValid = 0, OutBit = 0, InReady = 1.
- Reset mid-operation discards FIFO contents and phase immediately.
- Accept: a bit is accepted when InValid && InReady.
- Push: if the accepted bit is kept, it is pushed into the FIFO; if punctured, it is discarded.
- Phase: every accepted bit (kept or punctured) advances the phase.
- Period P and keep mask (phase index -> keep):
  - rate 1/2: P = 2, keep {0, 1}.
  - rate 2/3: P = 4, keep {0, 1, 2} (B1 dropped).
  - rate 3/4: P = 6, keep {0, 1, 2, 5} (B1 and A2 dropped; output order A0 B0 A1 B2).
- Phase wrap: phase wraps from P-1 to 0. Phase width is 3 bits.
- Start:
  - On Start, phase <= 0 and latched rate <= Rate.
  - If InValid is high in the same cycle, that bit is accepted as phase 0 under the new rate.
  - Start does not flush the FIFO; bits already queued still drain.
- InReady = !full, computed from registered occupancy only (no same-cycle pop bypass).
- Output side:
  - OutValid = !empty.
  - OutBit = FIFO head while nonempty, 0 when empty.
  - Pop on OutValid && OutReady.
- Latency: a kept bit accepted at edge n is visible on OutBit/OutValid after edge n (one register stage), provided the FIFO was empty.
- Simultaneous push and pop with FIFO nonempty: Level unchanged, order preserved.
- Push into an empty FIFO with OutReady high: the bit is not popped the same cycle (no bypass).
- Full: InReady = 0. Input bits are not accepted and the phase does not advance.
- Empty: an OutReady pulse has no effect.
- Pointers: read/write pointers are FIFO_AW bits and wrap naturally. Level is tracked by an up/down counter, saturating-free by construction.
- Ordering: output bit order equals input order of kept bits, with no gaps or duplicates.

Test Plan:
- Rate 1/2 passthrough:
  - Reset, then Start with Rate = 00.
  - Stream 10110010 with InValid = 1, OutReady = 1 -> output 10110010.
  - OutValid first high one cycle after the first accept.
- Rate 3/4:
  - Start with Rate = 10.
  - Input 101100111000 -> output 10101110 (8 bits).
  - Level never exceeds 1 with OutReady = 1.
- Rate 2/3:
  - Start with Rate = 01.
  - Input 11010110 -> output 110011 (6 bits).
  - Exactly 2 bits discarded.
- Backpressure, FIFO_AW = 3, rate 1/2:
  - Hold OutReady = 0 and feed 10 bits -> Level = 8, InReady = 0 after the 8th accept; bits 9 and 10 are held upstream.
  - Raise OutReady -> the 10 bits emerge in order.
  - Level returns to 0.
- Start mid-group, rate 3/4:
  - Accept 3 bits, then pulse Start with Rate = 01 alongside the 4th bit.
  - That bit is phase 0 of the 2/3 pattern.
  - Previously queued bits drain unchanged.
- Async reset mid-stream:
  - Assert Reset between edges with Level = 5.
  - Level = 0, OutValid = 0, OutBit = 0 immediately.
  - After release, rate = 1/2 until the next Start.

Source files
------------

// File: rtl/conv_puncturer.sv
// conv_puncturer: 802.11a rate-1/2 -> 1/2, 2/3, 3/4 puncturer with output FIFO
module conv_puncturer #(
  parameter int FIFO_AW = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [1:0]         Rate,
  input  logic               InBit,
  input  logic               InValid,
  output logic               InReady,
  output logic               OutBit,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [FIFO_AW:0]   Level
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW + 1)'(DEPTH);
  logic [1:0]         r_rate;
  logic [2:0]         r_phase;
  logic               r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0]   r_level;
  logic [1:0]         w_rate;
  logic [2:0]         w_phase, w_last;
  logic               w_keep, w_acc, w_push, w_pop;
  assign InReady  = r_level != FULL;
  assign OutValid = r_level != '0;
  assign OutBit   = OutValid & r_mem[r_rp];
  assign Level    = r_level;
  assign w_acc    = InValid && InReady;
  assign w_push   = w_acc && w_keep;
  assign w_pop    = OutValid && OutReady;
  // Start takes effect in its own cycle, so a coincident bit is phase 0 of the new rate
  always_comb begin
    w_rate  = Start ? Rate : r_rate;
    w_phase = Start ? 3'd0 : r_phase;
    w_last  = w_rate == 2'b01 ? 3'd3 : w_rate == 2'b10 ? 3'd5 : 3'd1;
    w_keep  = w_rate == 2'b01 ? (w_phase != 3'd3) :
              w_rate == 2'b10 ? (w_phase != 3'd3 && w_phase != 3'd4) : 1'b1;
  end
  // Rate/phase tracking, FIFO pointers and occupancy
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_rate  <= 2'b00;
      r_phase <= 3'd0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (Start) r_rate <= Rate;
      if (w_acc) r_phase <= (w_phase == w_last) ? 3'd0 : w_phase + 3'd1;
      else if (Start) r_phase <= 3'd0;
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop) r_level <= r_level + (FIFO_AW + 1)'(1);
      else if (!w_push && w_pop) r_level <= r_level - (FIFO_AW + 1)'(1);
    end
  end
  // FIFO storage; contents are meaningless outside the occupied window so no reset
  always_ff @(posedge Clock) begin
    if (w_push) r_mem[r_wp] <= InBit;
  end
endmodule

// File: tb/tb_conv_puncturer.sv
// tb_conv_puncturer: directed-vector bench for conv_puncturer
module tb_conv_puncturer;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [1:0] Rate = 2'b00;
  logic       InBit = 1'b0;
  logic       InValid = 1'b0;
  logic       OutReady = 1'b0;
  logic       InReady, OutBit, OutValid;
  logic [3:0] Level;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         max_lvl = 0;
  logic       got [$];

  conv_puncturer #(.FIFO_AW(3)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Rate(Rate),
    .InBit(InBit), .InValid(InValid), .InReady(InReady),
    .OutBit(OutBit), .OutValid(OutValid), .OutReady(OutReady), .Level(Level)
  );

  always #5 Clock = ~Clock;

  // Inputs change 1 time unit after posedge, so negedge values are the ones the next edge uses
  always @(negedge Clock) begin
    if (OutValid && OutReady) got.push_back(OutBit);
    if (int'(Level) > max_lvl) max_lvl = int'(Level);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic b, input logic st = 1'b0, input logic [1:0] r = 2'b00);
    int cnt = 0;
    InBit = b; InValid = 1'b1; Start = st; Rate = r;
    @(negedge Clock);
    while (!InReady && cnt < 200) begin
      @(posedge Clock); #1;
      Start = 1'b0;
      @(negedge Clock);
      cnt++;
    end
    if (cnt >= 200) chk("send_timeout", 32'(cnt), 32'd0);
    @(posedge Clock); #1;
    InValid = 1'b0; Start = 1'b0;
  endtask

  task automatic start_only(input logic [1:0] r);
    Start = 1'b1; Rate = r;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic send_vec(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send(v[i]);
  endtask

  task automatic drain();
    repeat (20) @(posedge Clock);
    #1;
  endtask

  task automatic chk_stream(input string tag, input logic [31:0] exp, input int n);
    logic [31:0] v = 0;
    chk({tag, "_count"}, 32'(got.size()), 32'(n));
    foreach (got[i]) v = (v << 1) | 32'(got[i]);
    chk({tag, "_bits"}, v, exp);
    got.delete();
  endtask

  initial begin
    #12 Reset = 1'b0;
    @(posedge Clock); #1;
    chk("rst_level", 32'(Level), 0);
    chk("rst_outvalid", 32'(OutValid), 0);
    chk("rst_outbit", 32'(OutBit), 0);
    chk("rst_inready", 32'(InReady), 1);

    // rate 1/2 passthrough with one-cycle latency
    start_only(2'b00);
    OutReady = 1'b1;
    got.delete();
    send(1'b1);
    chk("r12_latency_valid", 32'(OutValid), 1);
    chk("r12_latency_bit", 32'(OutBit), 1);
    send_vec(32'b0110010, 7);
    drain();
    chk_stream("r12", 32'b10110010, 8);

    // rate 3/4
    start_only(2'b10);
    max_lvl = 0;
    send_vec(32'b101100111000, 12);
    drain();
    chk_stream("r34", 32'b10101110, 8);
    chk("r34_maxlevel", 32'(max_lvl), 1);

    // rate 2/3
    start_only(2'b01);
    send_vec(32'b11010110, 8);
    drain();
    chk_stream("r23", 32'b110011, 6);

    // backpressure at rate 1/2
    start_only(2'b00);
    OutReady = 1'b0;
    send_vec(32'b11001011, 8);
    chk("bp_level_full", 32'(Level), 8);
    chk("bp_inready_low", 32'(InReady), 0);
    fork
      send_vec(32'b01, 2);
      begin
        repeat (3) @(posedge Clock);
        #1;
        chk("bp_held_level", 32'(Level), 8);
        chk("bp_held_outcount", 32'(got.size()), 0);
        OutReady = 1'b1;
      end
    join
    drain();
    chk_stream("bp", 32'b1100101101, 10);
    chk("bp_level_empty", 32'(Level), 0);

    // Start mid-group: 3/4 then switch to 2/3 alongside the 4th bit
    start_only(2'b10);
    OutReady = 1'b0;
    send_vec(32'b101, 3);
    send(1'b0, 1'b1, 2'b01);
    send_vec(32'b1101, 4);
    chk("mid_level", 32'(Level), 7);
    OutReady = 1'b1;
    drain();
    chk_stream("mid", 32'b1010111, 7);

    // async reset with Level = 5, then default rate 1/2
    start_only(2'b10);
    OutReady = 1'b0;
    send_vec(32'b1011011, 7);
    chk("ar_level_pre", 32'(Level), 5);
    chk("ar_outbit_pre", 32'(OutBit), 1);
    #2 Reset = 1'b1;
    #1;
    chk("ar_level", 32'(Level), 0);
    chk("ar_outvalid", 32'(OutValid), 0);
    chk("ar_outbit", 32'(OutBit), 0);
    chk("ar_inready", 32'(InReady), 1);
    @(posedge Clock); #1;
    Reset = 1'b0;
    got.delete();
    OutReady = 1'b1;
    send_vec(32'b111111, 6);
    drain();
    chk_stream("ar_r12", 32'b111111, 6);

    // OutReady while empty has no effect
    chk("empty_level", 32'(Level), 0);
    chk("empty_outvalid", 32'(OutValid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
